// File: rtl/sram_burst_reader.sv
// sram_burst_reader
//   Reads len_i beats from a synchronous single-port SRAM. Each beat is two
//   consecutive words starting at base_addr_i. The two words are packed into
//   one output beat, which is handed downstream with a valid/ready handshake.
//
//   Optional feature: define SRAM_RD_STALL_CNT_EN to build a saturating
//   counter of backpressure cycles. A backpressure cycle is one with
//   valid_o=1 and ready_i=0. The counter clears on each accepted command.
//   When the macro is undefined, stall_cnt_o is tied to zero.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      command strobe, only looked at while idle
//   base_addr_i  word address of the first SRAM word
//   len_i        number of output beats; zero completes without SRAM access
//   busy_o       high whenever a command is in flight
//   done_o       one-cycle completion pulse
//   sram_en_o    SRAM read enable
//   sram_we_o    SRAM write enable, always 0
//   sram_addr_o  SRAM word address
//   sram_data_i  SRAM read data, one cycle after the enable cycle
//   data_o       packed beat: low half = even word, high half = next word
//   valid_o      data_o valid
//   ready_i      downstream accepts the beat
//   stall_cnt_o  backpressure cycle counter
module sram_burst_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int N_ENTRIES    = 1024,
    parameter int DATA_WIDTH_O = 64,
    localparam int AW          = $clog2(N_ENTRIES)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [AW-1:0]           base_addr_i,
    input  logic [AW-1:0]           len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    sram_en_o,
    output logic                    sram_we_o,
    output logic [AW-1:0]           sram_addr_o,
    input  logic [DATA_WIDTH-1:0]   sram_data_i,
    output logic [DATA_WIDTH_O-1:0] data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [31:0]             stall_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        CAP,
        OUT,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_ENTRIES - 1);

    state_t          state_reg;
    logic [AW-1:0]   ptr_reg;
    logic [AW-1:0]   count_reg;
    logic [AW-1:0]   ptr_next;

    // Explicit wrap so that non-power-of-two depths also wrap to zero.
    assign ptr_next = (ptr_reg == LAST_ADDR) ? '0 : ptr_reg + AW'(1);

    assign sram_we_o = 1'b0;

    // All outputs are registered. Each transition loads the values that
    // belong to the state being entered, so the outputs line up with
    // state_reg.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            count_reg   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            sram_en_o   <= 1'b0;
            sram_addr_o <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            sram_en_o <= 1'b0;
            valid_o   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            ptr_reg     <= base_addr_i;
                            count_reg   <= len_i;
                            sram_en_o   <= 1'b1;
                            sram_addr_o <= base_addr_i;
                            state_reg   <= RD_LO;
                        end else begin
                            done_o    <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                RD_LO: begin
                    ptr_reg     <= ptr_next;
                    sram_en_o   <= 1'b1;
                    sram_addr_o <= ptr_next;
                    state_reg   <= RD_HI;
                end
                RD_HI: begin
                    // Word read in RD_LO arrives now.
                    ptr_reg                   <= ptr_next;
                    data_o[DATA_WIDTH-1:0]    <= sram_data_i;
                    state_reg                 <= CAP;
                end
                CAP: begin
                    // Word read in RD_HI arrives now.
                    data_o[DATA_WIDTH_O-1:DATA_WIDTH] <= sram_data_i;
                    count_reg <= count_reg - AW'(1);
                    valid_o   <= 1'b1;
                    state_reg <= OUT;
                end
                OUT: begin
                    if (ready_i) begin
                        if (count_reg != '0) begin
                            sram_en_o   <= 1'b1;
                            sram_addr_o <= ptr_reg;
                            state_reg   <= RD_LO;
                        end else begin
                            done_o    <= 1'b1;
                            state_reg <= DONE;
                        end
                    end else begin
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_RD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (state_reg == IDLE && start_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;

    localparam int DW = 32;
    localparam int N  = 1024;
    localparam int AW = 10;

    localparam int RDY_MANUAL = 0;
    localparam int RDY_ALWAYS = 1;
    localparam int RDY_RANDOM = 2;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] len_i;
    logic          busy_o;
    logic          done_o;
    logic          sram_en_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_data_i;
    logic [63:0]   data_o;
    logic          valid_o;
    logic          ready_i;
    logic [31:0]   stall_cnt_o;

    sram_burst_reader #(
        .DATA_WIDTH  (DW),
        .N_ENTRIES   (N),
        .DATA_WIDTH_O(64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sram_en_o   (sram_en_o),
        .sram_we_o   (sram_we_o),
        .sram_addr_o (sram_addr_o),
        .sram_data_i (sram_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, data one cycle after enable.
    logic [DW-1:0] mem [0:N-1];
    always @(posedge clk) begin
        if (sram_en_o) sram_data_i <= mem[sram_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int ready_mode = RDY_ALWAYS;
    always @(posedge clk) begin
        #1;
        if (ready_mode == RDY_ALWAYS) ready_i = 1'b1;
        else if (ready_mode == RDY_RANDOM) ready_i = ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    logic [63:0]   beats_q [$];
    int            addr_q  [$];
    int            en_cnt, done_cnt, done_cyc, first_valid_cyc, start_cyc;
    int            stall_model, proto_err;
    bit            hold_prev;
    logic [63:0]   held_data;

    task automatic mon_clear();
        beats_q.delete();
        addr_q.delete();
        en_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_model = 0; proto_err = 0; hold_prev = 0;
    endtask

    always @(negedge clk) begin
        if (sram_we_o) proto_err++;
        if (sram_en_o) begin
            en_cnt++;
            addr_q.push_back(int'(sram_addr_o));
            if (valid_o) proto_err++;
        end
        if (valid_o) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_prev && data_o !== held_data) proto_err++;
            if (!ready_i) begin
                stall_model++;
                hold_prev = 1;
                held_data = data_o;
            end else begin
                beats_q.push_back(data_o);
                hold_prev = 0;
            end
        end else begin
            hold_prev = 0;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] model_beat(input int base, input int k);
        return {mem[(base + 2*k + 1) % N], mem[(base + 2*k) % N]};
    endfunction

    task automatic issue_cmd(input int base, input int len);
        @(posedge clk); #1;
        mon_clear();
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        len_i       = AW'(len);
        start_cyc   = cyc;
        @(posedge clk); #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
        len_i       = AW'($urandom);
    endtask

    task automatic wait_done(input bit glitch);
        int i = 0;
        while (done_cnt == 0 && i < 2000) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (glitch && i == 5 && busy_o) begin
                start_i     = 1'b1;
                base_addr_i = AW'($urandom);
                len_i       = AW'($urandom_range(1, 7));
            end
            i++;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        if (done_cnt == 0) check("timeout_done", 64'(i), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_cmd(input int base, input int len, input int exp_lat,
                             input bit chk_b0, input logic [63:0] b0);
        check("beat_count", 64'(beats_q.size()), 64'(len));
        for (int k = 0; k < len && k < beats_q.size(); k++)
            check($sformatf("beat%0d", k), beats_q[k], model_beat(base, k));
        check("en_cycles", 64'(en_cnt), 64'(2 * len));
        for (int k = 0; k < 2 * len && k < addr_q.size(); k++)
            check($sformatf("addr%0d", k), 64'(addr_q[k]), 64'((base + k) % N));
        check("done_pulses", 64'(done_cnt), 64'(1));
        if (len > 0) check("first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'(4));
        if (exp_lat >= 0) check("done_lat", 64'(done_cyc - start_cyc), 64'(exp_lat));
        if (chk_b0 && beats_q.size() > 0) check("beat0_table", beats_q[0], b0);
`ifdef SRAM_RD_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt_o), 64'(stall_model));
`else
        check("stall_cnt", 64'(stall_cnt_o), 64'(0));
`endif
        check("protocol", 64'(proto_err), 64'(0));
        check("busy_after", 64'(busy_o), 64'(0));
    endtask

    typedef struct {
        int          base;
        int          len;
        bit          rnd_ready;
        bit          glitch;
        bit          chk_b0;
        logic [63:0] exp_b0;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] held;
        int          w;

        vecs[0] = '{16,   2, 1'b0, 1'b0, 1'b1, 64'h0000_00A1_0000_00A0, 9};
        vecs[1] = '{1023, 1, 1'b0, 1'b0, 1'b1, 64'h0000_C000_0000_C3FF, 5};
        vecs[2] = '{0,    0, 1'b0, 1'b0, 1'b0, 64'h0,                   1};
        vecs[3] = '{100,  3, 1'b0, 1'b1, 1'b0, 64'h0,                   13};
        vecs[4] = '{1020, 3, 1'b1, 1'b0, 1'b0, 64'h0,                   -1};
        vecs[5] = '{5,    1, 1'b1, 1'b1, 1'b0, 64'h0,                   -1};

        for (int i = 0; i < N; i++) mem[i] = $urandom;
        mem[16] = 32'hA0; mem[17] = 32'hA1; mem[18] = 32'hA2; mem[19] = 32'hA3;
        mem[0]  = 32'hC000; mem[1023] = 32'hC3FF;

        rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; ready_i = 1'b1;
        mon_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy_o),      64'(0));
        check("rst_done",  64'(done_o),      64'(0));
        check("rst_en",    64'(sram_en_o),   64'(0));
        check("rst_addr",  64'(sram_addr_o), 64'(0));
        check("rst_data",  data_o,           64'(0));
        check("rst_valid", 64'(valid_o),     64'(0));
        check("rst_stall", 64'(stall_cnt_o), 64'(0));
        rst_n = 1'b1;

        // Table-driven commands.
        for (int v = 0; v < 6; v++) begin
            ready_mode = vecs[v].rnd_ready ? RDY_RANDOM : RDY_ALWAYS;
            issue_cmd(vecs[v].base, vecs[v].len);
            wait_done(vecs[v].glitch);
            check_cmd(vecs[v].base, vecs[v].len, vecs[v].exp_lat, vecs[v].chk_b0, vecs[v].exp_b0);
            $display("vec %0d base=%0d len=%0d beats=%0d en=%0d", v, vecs[v].base,
                     vecs[v].len, beats_q.size(), en_cnt);
        end

        // Backpressure: ready low for 5 cycles while the beat is offered.
        ready_mode = RDY_MANUAL;
        ready_i = 1'b0;
        issue_cmd(200, 1);
        w = 0;
        while (!valid_o && w < 50) begin @(posedge clk); #1; w++; end
        check("stall_reach_out", 64'(valid_o), 64'(1));
        held = data_o;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_valid_held", 64'(valid_o), 64'(1));
            check("stall_data_held", data_o, held);
            check("stall_no_en", 64'(sram_en_o), 64'(0));
        end
        ready_i = 1'b1;
        wait_done(1'b0);
        check_cmd(200, 1, -1, 1'b0, 64'h0);
`ifdef SRAM_RD_STALL_CNT_EN
        check("stall_five", 64'(stall_cnt_o), 64'(5));
`else
        check("stall_five", 64'(stall_cnt_o), 64'(0));
`endif
        $display("stall test stall_cnt=%0d", stall_cnt_o);

        // Reset while a beat is being offered.
        ready_mode = RDY_MANUAL;
        ready_i = 1'b0;
        issue_cmd(40, 2);
        w = 0;
        while (!valid_o && w < 50) begin @(posedge clk); #1; w++; end
        check("abort_reach_out", 64'(valid_o), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",  64'(busy_o),      64'(0));
        check("abort_en",    64'(sram_en_o),   64'(0));
        check("abort_addr",  64'(sram_addr_o), 64'(0));
        check("abort_data",  data_o,           64'(0));
        check("abort_valid", 64'(valid_o),     64'(0));
        check("abort_stall", 64'(stall_cnt_o), 64'(0));
        mon_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode = RDY_ALWAYS;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(0));
        $display("reset abort test done");
        issue_cmd(40, 2);
        wait_done(1'b0);
        check_cmd(40, 2, 9, 1'b0, 64'h0);

        // Randomized commands against the reference model.
        for (int r = 0; r < 20; r++) begin
            int b, l;
            bit g;
            b = $urandom_range(0, N - 1);
            l = $urandom_range(0, 6);
            g = 1'($urandom_range(0, 1));
            ready_mode = RDY_RANDOM;
            issue_cmd(b, l);
            wait_done(g);
            check_cmd(b, l, -1, 1'b0, 64'h0);
            $display("rand %0d base=%0d len=%0d beats=%0d stalls=%0d", r, b, l,
                     beats_q.size(), stall_model);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
